instr_issue_unit: RTL and testbench

Upstream instruction sequencer for the 512-bit register processor.
- Holds a small program store loaded over a write port.
- Walks the program with a PC and drives the processor's 13-bit instruction input at one instruction per clock.
- Automatically inserts WAIT slots after load instructions, and stops on a HALT opcode that is never forwarded to the processor.

---
 rtl/instr_issue_unit.sv | 116 +++++++++++
 tb/tb_instr_issue_unit.sv | 192 +++++++++++++++++++
 2 files changed

// File: rtl/instr_issue_unit.sv
// instr_issue_unit: program store plus sequencer that feeds one instruction per clock to the 512-bit register processor
// Ports:
//   clk, rst (async, active-low)        clock and reset
//   prog_we, prog_addr, prog_data       program store write port (honoured only in IDLE/DONE)
//   start                               begin a run from address 0
//   stall                               freeze sequencing and emit WAIT
//   instruction                         registered instruction to the processor
//   pc                                  address of the next word to fetch
//   busy, done, err                     run in progress, run finished, sticky reserved-opcode flag
module instr_issue_unit #(
    parameter int IW        = 13,
    parameter int DEPTH     = 32,
    parameter int AW        = 5,
    parameter int LOAD_WAIT = 1
) (
    input  logic          clk,
    input  logic          rst,
    input  logic          prog_we,
    input  logic [AW-1:0] prog_addr,
    input  logic [IW-1:0] prog_data,
    input  logic          start,
    input  logic          stall,
    output logic [IW-1:0] instruction,
    output logic [AW-1:0] pc,
    output logic          busy,
    output logic          done,
    output logic          err
);
    localparam logic [IW-1:0] NOP = IW'(1);
    typedef enum logic [1:0] {S_IDLE, S_ISSUE, S_WAIT, S_DONE} state_t;
    state_t state, state_nx;
    logic [IW-1:0] mem [DEPTH];
    logic [IW-1:0] word, instr_nx;
    logic [AW-1:0] pc_nx;
    logic [2:0] op, cnt, cnt_nx;
    logic busy_nx, done_nx, err_nx, last, last_nx, at_end, is_load;
    assign word    = mem[pc];
    assign op      = word[IW-1:IW-3];
    assign at_end  = pc == AW'(DEPTH-1);
    assign is_load = op[2:1] == 2'b10 && LOAD_WAIT > 0;
    always_ff @(posedge clk)
        if (prog_we && (state == S_IDLE || state == S_DONE)) mem[prog_addr] <= prog_data;
    always_comb begin
        state_nx = state;
        instr_nx = NOP;
        pc_nx    = pc;
        cnt_nx   = cnt;
        busy_nx  = busy;
        done_nx  = done;
        err_nx   = err;
        last_nx  = last;
        case (state)
            S_IDLE, S_DONE:
                if (start) begin
                    state_nx = S_ISSUE;
                    pc_nx    = '0;
                    busy_nx  = 1'b1;
                    done_nx  = 1'b0;
                    err_nx   = 1'b0;
                    last_nx  = 1'b0;
                end
            S_ISSUE:
                if (!stall) begin
                    if (op == 3'b111) begin
                        state_nx = S_DONE;
                        busy_nx  = 1'b0;
                        done_nx  = 1'b1;
                    end else begin
                        if (op[2:1] == 2'b01) err_nx = 1'b1;
                        else instr_nx = word;
                        // pc saturates on the last word; the end flag finishes the run instead of wrapping
                        pc_nx   = at_end ? pc : pc + 1'b1;
                        last_nx = at_end;
                        if (is_load) begin
                            cnt_nx   = 3'(LOAD_WAIT);
                            state_nx = S_WAIT;
                        end else if (at_end) begin
                            state_nx = S_DONE;
                            busy_nx  = 1'b0;
                            done_nx  = 1'b1;
                        end
                    end
                end
            S_WAIT:
                if (!stall) begin
                    cnt_nx = cnt - 1'b1;
                    if (cnt == 3'd1) begin
                        state_nx = last ? S_DONE : S_ISSUE;
                        busy_nx  = !last;
                        done_nx  = last;
                    end
                end
            default: ;
        endcase
    end
    always_ff @(posedge clk or negedge rst)
        if (!rst) begin
            state       <= S_IDLE;
            instruction <= NOP;
            pc          <= '0;
            cnt         <= '0;
            busy        <= 1'b0;
            done        <= 1'b0;
            err         <= 1'b0;
            last        <= 1'b0;
        end else begin
            state       <= state_nx;
            instruction <= instr_nx;
            pc          <= pc_nx;
            cnt         <= cnt_nx;
            busy        <= busy_nx;
            done        <= done_nx;
            err         <= err_nx;
            last        <= last_nx;
        end
endmodule

// File: tb/tb_instr_issue_unit.sv
// tb_instr_issue_unit: scoreboard bench for instr_issue_unit with randomized programs and stalls
module tb_instr_issue_unit;
    localparam int DEPTH = 32;
    localparam int LW = 1;
    localparam int LIMIT = 2000;
    localparam logic [12:0] NOP = 13'h0001;
    logic clk = 0, rst = 1, prog_we = 0, start = 0, stall = 0;
    logic [4:0] prog_addr = 0;
    logic [12:0] prog_data = 0;
    logic [12:0] instruction;
    logic [4:0] pc;
    logic busy, done, err;
    instr_issue_unit #(.IW(13), .DEPTH(DEPTH), .AW(5), .LOAD_WAIT(LW)) dut (
        .clk(clk), .rst(rst), .prog_we(prog_we), .prog_addr(prog_addr), .prog_data(prog_data),
        .start(start), .stall(stall), .instruction(instruction), .pc(pc), .busy(busy),
        .done(done), .err(err)
    );
    always #5 clk = ~clk;
    logic [12:0] prog [DEPTH];
    logic [12:0] sb [$];
    int n_chk = 0, n_pass = 0;
    logic [4:0] exp_pc;
    logic exp_err;
    task automatic chk(input string nm, input logic [31:0] got, input logic [31:0] want);
        n_chk++;
        if (got === want) n_pass++;
        else $display("FAIL %s: got %h expected %h", nm, got, want);
    endtask
    // reference: walk the program word by word and list every non-stalled output slot
    task automatic plan();
        sb.delete();
        exp_err = 0;
        exp_pc = 5'(DEPTH - 1);
        for (int a = 0; a < DEPTH; a++) begin
            logic [2:0] op;
            op = prog[a][12:10];
            if (op == 3'd7) begin
                sb.push_back(NOP);
                exp_pc = 5'(a);
                return;
            end
            if (op == 3'd2 || op == 3'd3) begin
                sb.push_back(NOP);
                exp_err = 1;
            end else sb.push_back(prog[a]);
            if (op == 3'd4 || op == 3'd5) repeat (LW) sb.push_back(NOP);
        end
    endtask
    bit act = 0;
    logic st, s, r;
    logic [4:0] pc_prev;
    logic [12:0] e;
    always begin
        @(posedge clk);
        st = stall;
        s = start;
        r = rst;
        #1;
        if (!r) act = 0;
        else if (act) begin
            if (st) begin
                chk("stall_nop", instruction, NOP);
                chk("stall_pc", pc, pc_prev);
            end else if (sb.size() > 0) begin
                e = sb.pop_front();
                chk("slot", instruction, e);
                chk("done_timing", done, sb.size() == 0);
                chk("busy_timing", busy, sb.size() != 0);
                if (sb.size() == 0) begin
                    act = 0;
                    chk("end_pc", pc, exp_pc);
                    chk("end_err", err, exp_err);
                end
            end
        end else if (s && sb.size() > 0) act = 1;
        pc_prev = pc;
    end
    task automatic load_prog(input bit skip0);
        for (int a = DEPTH - 1; a >= 0; a--) begin
            @(negedge clk);
            prog_we = 1;
            prog_addr = a[4:0];
            prog_data = (a == 0 && skip0) ? 13'h1C00 : prog[a];
        end
        @(negedge clk);
        prog_we = 0;
    endtask
    task automatic run(input int pct, input logic [31:0] mask, input bit w0, input bit inject);
        int g;
        plan();
        @(negedge clk);
        start = 1;
        if (w0) begin
            prog_we = 1;
            prog_addr = 0;
            prog_data = prog[0];
        end
        @(negedge clk);
        g = 0;
        while (sb.size() > 0 && g < LIMIT) begin
            stall = (g < 32 && mask[g]) || ($urandom_range(99) < pct);
            if (inject && g == 2) begin
                start = 1;
                prog_we = 1;
                prog_addr = 0;
                prog_data = 13'h1C00;
            end else begin
                start = 0;
                prog_we = 0;
            end
            @(negedge clk);
            g++;
        end
        stall = 0;
        start = 0;
        prog_we = 0;
        chk("run_finished", g < LIMIT, 1);
        if (g >= LIMIT) begin
            sb.delete();
            rst = 0;
            @(negedge clk);
            rst = 1;
        end
        @(negedge clk);
    endtask
    task automatic set_prog(input logic [12:0] w0, input logic [12:0] w1, input logic [12:0] w2,
                            input logic [12:0] w3);
        for (int a = 0; a < DEPTH; a++) prog[a] = 13'h1C00;
        prog[0] = w0;
        prog[1] = w1;
        prog[2] = w2;
        prog[3] = w3;
    endtask
    initial begin
        #1 rst = 0;
        @(negedge clk);
        @(negedge clk);
        chk("rst_instr", instruction, NOP);
        chk("rst_pc", pc, 0);
        chk("rst_busy", busy, 0);
        chk("rst_done", done, 0);
        chk("rst_err", err, 0);
        rst = 1;
        set_prog(13'h1000, 13'h1102, 13'h0000, 13'h1C00);
        load_prog(1);
        run(0, 0, 1, 0);
        set_prog(13'h1A05, 13'h1405, 13'h1C00, 13'h1C00);
        load_prog(0);
        run(0, 32'b1110, 0, 0);
        set_prog(13'h0800, 13'h0400, 13'h1C00, 13'h1C00);
        load_prog(0);
        run(0, 0, 0, 0);
        for (int a = 0; a < DEPTH; a++) prog[a] = 13'h0000;
        load_prog(0);
        run(0, 0, 0, 0);
        set_prog(13'h1000, 13'h1102, 13'h0000, 13'h1C00);
        load_prog(0);
        plan();
        @(negedge clk);
        start = 1;
        @(negedge clk);
        start = 0;
        @(posedge clk);
        #3 rst = 0;
        #1;
        chk("midrun_rst_instr", instruction, NOP);
        chk("midrun_rst_pc", pc, 0);
        chk("midrun_rst_busy", busy, 0);
        sb.delete();
        @(negedge clk);
        @(negedge clk);
        rst = 1;
        run(0, 0, 0, 0);
        run(0, 0, 0, 1);
        run(0, 0, 0, 0);
        for (int t = 0; t < 12; t++) begin
            for (int a = 0; a < DEPTH; a++) begin
                int k;
                logic [2:0] op;
                k = $urandom_range(15);
                op = k < 4 ? 3'd0 : k < 6 ? 3'd1 : k < 9 ? 3'd4 : k < 11 ? 3'd5 :
                     k < 13 ? 3'd6 : k == 13 ? 3'(2 + $urandom_range(1)) : k == 14 ? 3'd7 : 3'd0;
                prog[a] = {op, 10'($urandom)};
                if (k == 15) prog[a][7:0] = 8'd1;
            end
            load_prog(t[0]);
            run(20, 0, t[0], 0);
        end
        $display("%0d/%0d checks passed", n_pass, n_chk);
        $finish;
    end
endmodule
